vga_sync_gen: RTL and testbench



---
 rtl/vga_sync_gen.sv | 123 ++++++++++++
 tb/tb_vga_sync_gen.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/vga_sync_gen.sv
// -----------------------------------------------------------------------------
// vga_sync_gen
//   Raster timing generator for the pong display pipeline. The system clock is
//   divided down to a pixel tick, and horizontal and vertical counters walk the
//   raster (640x480@60 with the default parameters). The current pixel
//   coordinate drives the glyph and sprite renderers and the colour mux.
//
// Ports
//   clk         in   system clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   en          in   run enable; low freezes counters and registered outputs
//   p_tick      out  one-clk pulse marking a pixel advance
//   x           out  horizontal count, 0..H_TOTAL-1
//   y           out  vertical count, 0..V_TOTAL-1
//   hsync       out  horizontal sync, active low
//   vsync       out  vertical sync, active low
//   video_on    out  high inside the visible window
//   frame_start out  one-clk pulse in the cycle the raster reads (0,0) after a wrap
// -----------------------------------------------------------------------------
module vga_sync_gen #(
  parameter int CLK_DIV   = 4,
  parameter int H_DISPLAY = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  output logic       p_tick,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic       frame_start
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_DISPLAY);
  localparam logic [9:0] V_VIS    = 10'(V_DISPLAY);
  localparam logic [9:0] HS_START = 10'(H_DISPLAY + H_FRONT);
  localparam logic [9:0] HS_END   = 10'(H_DISPLAY + H_FRONT + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_DISPLAY + V_FRONT);
  localparam logic [9:0] VS_END   = 10'(V_DISPLAY + V_FRONT + V_SYNC);

  // Half-open window test [lo, hi) used for both sync pulses.
  function automatic logic in_window(input logic [9:0] v,
                                     input logic [9:0] lo,
                                     input logic [9:0] hi);
    return (v >= lo) && (v < hi);
  endfunction

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [9:0]       x_q, x_d;
  logic [9:0]       y_q, y_d;
  logic             hsync_q, hsync_d;
  logic             vsync_q, vsync_d;
  logic             frame_start_q, frame_start_d;
  logic             p_tick_c;

  always_comb begin
    // With CLK_DIV=1 div_cnt stays at 0 == DIV_LAST, so p_tick follows en.
    p_tick_c  = en && (div_cnt_q == DIV_LAST);

    div_cnt_d = div_cnt_q;
    if (en) begin
      div_cnt_d = (div_cnt_q == DIV_LAST) ? '0 : div_cnt_q + DIV_W'(1);
    end

    x_d = x_q;
    y_d = y_q;
    if (p_tick_c) begin
      x_d = (x_q == H_LAST) ? 10'd0 : x_q + 10'd1;
      if (x_q == H_LAST) begin
        y_d = (y_q == V_LAST) ? 10'd0 : y_q + 10'd1;
      end
    end

    // Syncs are decoded from the next-state coordinate so that the registered
    // pulse lines up with the registered x/y in the same cycle.
    hsync_d       = !in_window(x_d, HS_START, HS_END);
    vsync_d       = !in_window(y_d, VS_START, VS_END);
    frame_start_d = p_tick_c && (x_q == H_LAST) && (y_q == V_LAST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_q     <= '0;
      x_q           <= '0;
      y_q           <= '0;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      frame_start_q <= 1'b0;
    end else begin
      div_cnt_q     <= div_cnt_d;
      x_q           <= x_d;
      y_q           <= y_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign p_tick      = p_tick_c;
  assign x           = x_q;
  assign y           = y_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign video_on    = (x_q < H_VIS) && (y_q < V_VIS);
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// -----------------------------------------------------------------------------
// tb_vga_sync_gen
//   Directed bench. Instance a uses the default 640x480 timing with CLK_DIV=4
//   (divider, line, enable freeze). Instance b uses CLK_DIV=1 with default
//   horizontal timing and a shortened 8-line frame (vsync on y=5..6) so a
//   whole frame and a mid-sync reset fit in a short run.
// -----------------------------------------------------------------------------
module tb_vga_sync_gen;

  logic       clk;
  logic       rst_a_n, en_a, rst_b_n, en_b;
  logic       p_tick_a, hsync_a, vsync_a, video_on_a, frame_start_a;
  logic [9:0] x_a, y_a;
  logic       p_tick_b, hsync_b, vsync_b, video_on_b, frame_start_b;
  logic [9:0] x_b, y_b;

  int checks = 0;
  int errors = 0;

  vga_sync_gen #(.CLK_DIV(4)) u_dut_a (
    .clk(clk), .rst_n(rst_a_n), .en(en_a), .p_tick(p_tick_a),
    .x(x_a), .y(y_a), .hsync(hsync_a), .vsync(vsync_a),
    .video_on(video_on_a), .frame_start(frame_start_a)
  );

  vga_sync_gen #(
    .CLK_DIV(1), .V_DISPLAY(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1)
  ) u_dut_b (
    .clk(clk), .rst_n(rst_b_n), .en(en_b), .p_tick(p_tick_b),
    .x(x_b), .y(y_b), .hsync(hsync_b), .vsync(vsync_b),
    .video_on(video_on_b), .frame_start(frame_start_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance n rising edges, then park on the following falling edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  int hs_low, ticks, vo_cnt, vs_low, fs_cnt, fs_at;

  initial begin
    rst_a_n = 1'b0; en_a = 1'b1;
    rst_b_n = 1'b0; en_b = 1'b1;
    step(2);

    // Reset state, both instances
    chk("a_rst_x", x_a, 0);
    chk("a_rst_y", y_a, 0);
    chk("a_rst_hsync", hsync_a, 1);
    chk("a_rst_vsync", vsync_a, 1);
    chk("a_rst_fs", frame_start_a, 0);
    chk("a_rst_ptick", p_tick_a, 0);
    chk("a_rst_video_on", video_on_a, 1);
    chk("b_rst_ptick_div1", p_tick_b, 1);
    chk("b_rst_fs", frame_start_b, 0);

    // Divider: p_tick on the 3rd edge after release (div_cnt==3), x 0->1 on the 4th
    rst_a_n = 1'b1;
    step(1); chk("a_ptick_c1", p_tick_a, 0);
    step(1); chk("a_ptick_c2", p_tick_a, 0);
    step(1); chk("a_ptick_c3", p_tick_a, 1); chk("a_x_before_tick", x_a, 0);
    step(1); chk("a_x_after_tick", x_a, 1); chk("a_ptick_c4", p_tick_a, 0);
    chk("a_y_line0", y_a, 0);

    // Enable freeze at x=300 with the divider at its last count
    step(4*299);
    step(3);
    chk("a_x300", x_a, 300);
    chk("a_ptick_pre_freeze", p_tick_a, 1);
    en_a = 1'b0; #1;
    chk("a_ptick_en0", p_tick_a, 0);
    step(37);
    chk("a_frozen_x", x_a, 300);
    chk("a_frozen_y", y_a, 0);
    chk("a_frozen_ptick", p_tick_a, 0);
    chk("a_frozen_hsync", hsync_a, 1);
    en_a = 1'b1; #1;
    chk("a_resume_ptick", p_tick_a, 1);
    step(1);
    chk("a_resume_x301", x_a, 301);
    chk("a_resume_ptick_off", p_tick_a, 0);

    // Horizontal boundaries
    step(4*338); chk("a_x639", x_a, 639); chk("a_vo_639", video_on_a, 1);
    step(4);     chk("a_vo_640", video_on_a, 0);
    step(4*15);  chk("a_x655", x_a, 655); chk("a_hs_655", hsync_a, 1);
    step(4);     chk("a_hs_656", hsync_a, 0);
    step(4*95);  chk("a_x751", x_a, 751); chk("a_hs_751", hsync_a, 0);
    step(4);     chk("a_hs_752", hsync_a, 1);
    step(4*47);  chk("a_x799", x_a, 799); chk("a_y799", y_a, 0);
    step(4);     chk("a_wrap_x", x_a, 0); chk("a_wrap_y", y_a, 1);
    chk("a_wrap_fs", frame_start_a, 0);

    // One full line measured clock by clock
    hs_low = 0; ticks = 0;
    for (int i = 0; i < 3200; i++) begin
      step(1);
      if (!hsync_a) hs_low++;
      if (p_tick_a) ticks++;
    end
    chk("a_hsync_low_clks", hs_low, 384);
    chk("a_line_pticks", ticks, 800);
    chk("a_line2_x", x_a, 0);
    chk("a_line2_y", y_a, 2);

    // Instance b: full 800x8 frame at one pixel per clock
    rst_b_n = 1'b1;
    vo_cnt = 0; vs_low = 0; fs_cnt = 0; fs_at = 0;
    for (int i = 1; i <= 6400; i++) begin
      step(1);
      if (i == 1) chk("b_x_every_clk", x_b, 1);
      if (i == 800) begin
        chk("b_line_wrap_x", x_b, 0);
        chk("b_line_wrap_y", y_b, 1);
      end
      if (video_on_b) vo_cnt++;
      if (!vsync_b) vs_low++;
      if (frame_start_b) begin
        fs_cnt++;
        fs_at = i;
      end
    end
    chk("b_video_on_cnt", vo_cnt, 2560);
    chk("b_vsync_low_cnt", vs_low, 1600);
    chk("b_fs_count", fs_cnt, 1);
    chk("b_fs_period", fs_at, 6400);
    chk("b_frame_x", x_b, 0);
    chk("b_frame_y", y_b, 0);
    chk("b_fs_now", frame_start_b, 1);
    step(1);
    chk("b_fs_one_clk", frame_start_b, 0);
    chk("b_x_after_frame", x_b, 1);

    // Enable low with CLK_DIV=1
    en_b = 1'b0; #1;
    chk("b_ptick_en0", p_tick_b, 0);
    step(10);
    chk("b_frozen_x", x_b, 1);
    en_b = 1'b1;

    // Asynchronous reset inside both sync pulses (x=700, y=5)
    step(4699);
    chk("b_x700", x_b, 700);
    chk("b_y5", y_b, 5);
    chk("b_hs_low", hsync_b, 0);
    chk("b_vs_low", vsync_b, 0);
    #2 rst_b_n = 1'b0;
    #1;
    chk("b_async_x", x_b, 0);
    chk("b_async_y", y_b, 0);
    chk("b_async_hsync", hsync_b, 1);
    chk("b_async_vsync", vsync_b, 1);
    chk("b_async_fs", frame_start_b, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
